// File: rtl/sensor_hit_capture.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_hit_capture
//  Purpose  : Synchronise and debounce the sensor box code, turn each new
//             stable non-idle code into one valid/ready hit event, and drive
//             the LED echo, saturating hit counter and HEX digit.
//  Revision : 1.0  initial release
// ============================================================================
module sensor_hit_capture #(
    parameter int CODE_W        = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int IDLE_CODE     = 0,
    parameter int ADDR_OFFSET   = 1,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] sensor_code,
    input  logic              hit_ready,
    input  logic              clear_stats,
    output logic [CODE_W-1:0] led_out,
    output logic              hit_valid,
    output logic [CODE_W-1:0] box_addr,
    output logic [CNT_W-1:0]  hit_count,
    output logic              overrun,
    output logic [6:0]        hex_display
);

    // Active-low segments, bit 0 = a .. bit 6 = g.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    localparam int                c_FW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_FW-1:0]   c_CNT_MAX = c_FW'(STABLE_CYCLES - 1);
    localparam logic [CODE_W-1:0] c_IDLE    = CODE_W'(IDLE_CODE);
    localparam logic [CODE_W-1:0] c_OFFSET  = CODE_W'(ADDR_OFFSET);
    localparam logic [6:0]        c_HEX_RST = f_seg(4'(c_IDLE));

    logic [CODE_W-1:0] r_s1;
    logic [CODE_W-1:0] r_s2;
    logic [CODE_W-1:0] r_candidate;
    logic [c_FW-1:0]   r_cnt;
    logic [CODE_W-1:0] r_stable;
    logic [CODE_W-1:0] r_led;
    logic              r_hit_valid;
    logic [CODE_W-1:0] r_box_addr;
    logic [CNT_W-1:0]  r_hit_count;
    logic              r_overrun;
    logic [6:0]        r_hex;

    logic              w_accept;
    logic              w_event;
    logic              w_take;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count_base;
    logic [CNT_W-1:0]  w_count_next;

    // The candidate has survived the full window and differs from the current code.
    assign w_accept = (r_s2 == r_candidate) && (r_cnt == c_CNT_MAX) && (r_candidate != r_stable);
    assign w_event  = w_accept && (r_candidate != c_IDLE);
    assign w_take   = w_event && (!r_hit_valid || hit_ready);
    assign w_drop   = w_event && r_hit_valid && !hit_ready;

    // Clear takes effect before the same-cycle event is counted.
    assign w_count_base = clear_stats ? '0 : r_hit_count;
    assign w_count_next = (w_event && (w_count_base != '1)) ? w_count_base + CNT_W'(1) : w_count_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_led       <= '0;
            r_candidate <= c_IDLE;
            r_cnt       <= '0;
            r_stable    <= c_IDLE;
        end else begin
            r_s1  <= sensor_code;
            r_s2  <= r_s1;
            r_led <= r_s2;
            if (r_s2 != r_candidate) begin
                r_candidate <= r_s2;
                r_cnt       <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_FW'(1);
            end else if (w_accept) begin
                r_stable <= r_candidate;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_valid <= 1'b0;
            r_box_addr  <= '0;
            r_hit_count <= '0;
            r_overrun   <= 1'b0;
            r_hex       <= c_HEX_RST;
        end else begin
            if (w_take) begin
                r_hit_valid <= 1'b1;
                r_box_addr  <= r_candidate + c_OFFSET;
            end else if (hit_ready) begin
                r_hit_valid <= 1'b0;
            end
            r_hit_count <= w_count_next;
            r_overrun   <= (r_overrun & ~clear_stats) | w_drop;
            r_hex       <= f_seg(4'(r_stable));
        end
    end

    assign led_out     = r_led;
    assign hit_valid   = r_hit_valid;
    assign box_addr    = r_box_addr;
    assign hit_count   = r_hit_count;
    assign overrun     = r_overrun;
    assign hex_display = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_sensor_hit_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sensor_hit_capture
//  Purpose  : Directed and randomized stimulus for sensor_hit_capture, checked
//             against a window-based reference model of the sensor filter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sensor_hit_capture;

    localparam int c_S    = 4;
    localparam int c_IDLE = 0;
    localparam int c_OFF  = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sensor_code;
    logic       hit_ready;
    logic       clear_stats;

    logic [2:0] led_out, box_addr, w_led2, w_box2;
    logic       hit_valid, overrun, w_hv2, w_ov2;
    logic [7:0] hit_count;
    logic [1:0] w_hc2;
    logic [6:0] hex_display, w_hex2;

    sensor_hit_capture u_dut (
        .clk(clk), .reset(reset), .sensor_code(sensor_code), .hit_ready(hit_ready),
        .clear_stats(clear_stats), .led_out(led_out), .hit_valid(hit_valid),
        .box_addr(box_addr), .hit_count(hit_count), .overrun(overrun), .hex_display(hex_display)
    );

    sensor_hit_capture #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .sensor_code(sensor_code), .hit_ready(hit_ready),
        .clear_stats(clear_stats), .led_out(w_led2), .hit_valid(w_hv2),
        .box_addr(w_box2), .hit_count(w_hc2), .overrun(w_ov2), .hex_display(w_hex2)
    );

    always #5 clk = ~clk;

    logic [6:0] hextab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw samples since reset and the filter readings derived from them.
    int raws[$];
    int rd[$];
    int m_stable, m_led, m_hexc, m_hv, m_addr, m_cnt, m_ov;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        raws.delete();
        rd.delete();
        m_stable = c_IDLE;
        m_hexc   = c_IDLE;
        m_led    = 0;
        m_hv     = 0;
        m_addr   = 0;
        m_cnt    = 0;
        m_ov     = 0;
    endtask

    task automatic model_edge(input int code, input bit rdy, input bit clr);
        int reading;
        bit same;
        bit accept;
        bit ev;
        // The filter sees the code sampled two edges earlier.
        reading = (raws.size() >= 2) ? raws[raws.size()-2] : 0;
        raws.push_back(code);
        if (raws.size() > 2) void'(raws.pop_front());
        rd.push_back(reading);
        if (rd.size() > c_S + 1) void'(rd.pop_front());
        m_led  = reading;
        m_hexc = m_stable;
        accept = 1'b0;
        if (rd.size() == c_S + 1 && reading != m_stable) begin
            same = 1'b1;
            foreach (rd[i]) if (rd[i] != reading) same = 1'b0;
            accept = same;
        end
        ev = accept && (reading != c_IDLE);
        if (accept) m_stable = reading;
        if (clr) begin
            m_cnt = 0;
            m_ov  = 0;
        end
        if (ev) begin
            m_cnt++;
            if (!m_hv || rdy) begin
                m_hv   = 1;
                m_addr = (reading + c_OFF) % 8;
            end else begin
                m_ov = 1;
            end
        end else if (m_hv && rdy) begin
            m_hv = 0;
        end
    endtask

    task automatic check_all();
        check_val("led_out",     led_out,     m_led);
        check_val("hit_valid",   hit_valid,   m_hv);
        check_val("box_addr",    box_addr,    m_addr);
        check_val("hit_count",   hit_count,   sat(m_cnt, 255));
        check_val("overrun",     overrun,     m_ov);
        check_val("hex_display", hex_display, hextab[m_hexc]);
        check_val("sat_count",   w_hc2,       sat(m_cnt, 3));
    endtask

    task automatic cyc(input int code, input bit rdy, input bit clr);
        sensor_code = 3'(code);
        hit_ready   = rdy;
        clear_stats = clr;
        @(posedge clk);
        model_edge(code, rdy, clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input int code, input bit rdy, input bit clr, input int n);
        for (int k = 0; k < n; k++) cyc(code, rdy, clr);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        sensor_code = 3'd5;
        hit_ready   = 1'b0;
        clear_stats = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        check_val("rst_hex", hex_display, 7'b1000000);
        reset = 1'b0;

        // Steady code 5 after release: event on edge 7.
        for (int i = 1; i <= 10; i++) begin
            cyc(5, 1'b0, 1'b0);
            if (i == 6) check_val("t1_hv_edge6", hit_valid, 0);
            if (i == 7) begin
                check_val("t1_hv_edge7", hit_valid, 1);
                check_val("t1_addr", box_addr, 6);
                check_val("t1_cnt", hit_count, 1);
            end
        end
        hold(0, 1'b1, 1'b0, 10);

        // Short glitch never reaches the stable code.
        hold(3, 1'b1, 1'b0, 3);
        hold(0, 1'b1, 1'b0, 10);
        check_val("t2_hex", hex_display, 7'b1000000);
        check_val("t2_cnt", hit_count, 1);

        // Back-pressure: second event dropped.
        cyc(0, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b0, 10);
        hold(4, 1'b0, 1'b0, 10);
        check_val("t3_addr", box_addr, 3);
        check_val("t3_ovr", overrun, 1);
        check_val("t3_cnt", hit_count, 2);
        cyc(4, 1'b1, 1'b0);
        check_val("t3_hv_acc", hit_valid, 0);

        // Accept and new event on the same edge.
        cyc(4, 1'b0, 1'b1);
        hold(1, 1'b0, 1'b0, 10);
        for (int i = 1; i <= 10; i++) begin
            cyc(6, (i == 7), 1'b0);
            if (i == 7) begin
                check_val("t4_hv", hit_valid, 1);
                check_val("t4_addr", box_addr, 7);
                check_val("t4_ovr", overrun, 0);
            end
        end

        // Address wrap, hex of 7, counter saturation and clear.
        hold(7, 1'b1, 1'b0, 10);
        check_val("t5_addr_wrap", box_addr, 0);
        check_val("t5_hex7", hex_display, 7'b1111000);
        cyc(7, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) hold((k % 2 == 1) ? 2 : 3, 1'b1, 1'b0, 9);
        check_val("t5_sat", w_hc2, 3);
        check_val("t5_cnt5", hit_count, 5);
        cyc(3, 1'b1, 1'b1);
        check_val("t5_clr", w_hc2, 0);

        // Async reset mid-filter, then while a hit is pending.
        hold(0, 1'b1, 1'b0, 10);
        hold(5, 1'b0, 1'b0, 5);
        do_reset();
        check_val("t6_hv_rst", hit_valid, 0);
        hold(5, 1'b0, 1'b0, 6);
        check_val("t6_no_early", hit_valid, 0);
        cyc(5, 1'b0, 1'b0);
        check_val("t6_new_evt", hit_valid, 1);
        do_reset();
        check_val("t6_hv_rst2", hit_valid, 0);
        check_val("t6_cnt_rst2", hit_count, 0);
        hold(0, 1'b0, 1'b0, 10);
        check_val("t6_quiet", hit_valid, 0);

        // Randomized segments.
        for (int seg = 0; seg < 150; seg++) begin
            int code;
            int len;
            code = int'($urandom_range(0, 7));
            len  = int'($urandom_range(1, 12));
            for (int j = 0; j < len; j++)
                cyc(code, ($urandom_range(0, 2) == 0), ($urandom_range(0, 30) == 0));
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
